// File: rtl/img_line_tap3_if.sv
// Pixel stream in, three-row tap column out, for img_line_tap3.
interface img_line_tap3_if #(
   parameter int unsigned IMG_WIDTH_DATA = 24
) ();

   logic                      in_valid;
   logic                      in_sof;
   logic [IMG_WIDTH_DATA-1:0] in_data;

   logic                      out_valid;
   logic                      out_sof;
   logic                      out_eol;
   logic [10:0]               out_col;
   logic [9:0]                out_row;
   logic [IMG_WIDTH_DATA-1:0] tap0;
   logic [IMG_WIDTH_DATA-1:0] tap1;
   logic [IMG_WIDTH_DATA-1:0] tap2;

   // Tap block side: consumes the raster, produces columns.
   modport slave (
      input  in_valid, in_sof, in_data,
      output out_valid, out_sof, out_eol, out_col, out_row, tap0, tap1, tap2
   );

   // Pipeline side: drives the raster, consumes columns.
   modport master (
      output in_valid, in_sof, in_data,
      input  out_valid, out_sof, out_eol, out_col, out_row, tap0, tap1, tap2
   );

endinterface

// File: rtl/img_line_tap3.sv
// Three-row line-buffer tap: per accepted pixel emits the column (row, row-1, row-2)
// one cycle later. lineA holds the previous row, lineB the row before that.
module img_line_tap3 #(
   parameter int unsigned IMG_WIDTH_DATA = 24,
   parameter int unsigned IMG_WIDTH_LINE = 800,
   parameter int unsigned IMG_HEIGHT     = 600
) (
   input  logic           clk,
   input  logic           reset_n,
   img_line_tap3_if.slave pix
);

   localparam int unsigned AddrW   = $clog2(IMG_WIDTH_LINE);
   localparam logic [10:0] ColLast = 11'(IMG_WIDTH_LINE - 1);
   localparam logic [9:0]  RowLast = 10'(IMG_HEIGHT - 1);

   logic [10:0] col_q, col_d, pos_col;
   logic [9:0]  row_q, row_d, pos_row;
   logic [AddrW-1:0] rd_addr;

   logic [IMG_WIDTH_DATA-1:0] line_a [IMG_WIDTH_LINE];
   logic [IMG_WIDTH_DATA-1:0] line_b [IMG_WIDTH_LINE];
   logic [IMG_WIDTH_DATA-1:0] rd_a_q, rd_b_q;

   logic                      valid_q, sof_q, eol_q;
   logic [10:0]               col1_q;
   logic [9:0]                row1_q;
   logic [IMG_WIDTH_DATA-1:0] data_q;

   // Position of the incoming pixel (sof forces 0,0) and the raster position after it.
   always_comb begin
      pos_col = pix.in_sof ? '0 : col_q;
      pos_row = pix.in_sof ? '0 : row_q;
      col_d   = pos_col + 11'd1;
      row_d   = pos_row;
      if (pos_col == ColLast) begin
         col_d = '0;
         row_d = (pos_row == RowLast) ? '0 : pos_row + 10'd1;
      end
   end

   assign rd_addr = pos_col[AddrW-1:0];

   // Line memories: registered read-before-write. No reset; borders are masked on output.
   always_ff @(posedge clk) begin
      if (pix.in_valid) begin
         rd_a_q          <= line_a[rd_addr];
         rd_b_q          <= line_b[rd_addr];
         line_a[rd_addr] <= pix.in_data;
      end
      // lineB column c never collides with the stage-0 read at c+1 (width >= 2)
      if (valid_q) begin
         line_b[col1_q[AddrW-1:0]] <= rd_a_q;
      end
   end

   // Raster counters and stage-1 pipeline registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         col_q   <= '0;
         row_q   <= '0;
         valid_q <= 1'b0;
         sof_q   <= 1'b0;
         eol_q   <= 1'b0;
         col1_q  <= '0;
         row1_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= pix.in_valid;
         sof_q   <= pix.in_valid && (pos_col == '0) && (pos_row == '0);
         eol_q   <= pix.in_valid && (pos_col == ColLast);
         if (pix.in_valid) begin
            col_q  <= col_d;
            row_q  <= row_d;
            col1_q <= pos_col;
            row1_q <= pos_row;
            data_q <= pix.in_data;
         end
      end
   end

   // Reset clears row1_q, so the masks also hide the unreset read registers.
   assign pix.out_valid = valid_q;
   assign pix.out_sof   = sof_q;
   assign pix.out_eol   = eol_q;
   assign pix.out_col   = col1_q;
   assign pix.out_row   = row1_q;
   assign pix.tap0      = data_q;
   assign pix.tap1      = (row1_q == 10'd0) ? '0 : rd_a_q;
   assign pix.tap2      = (row1_q < 10'd2) ? '0 : rd_b_q;

endmodule

// File: tb/tb_img_line_tap3.sv
// Randomized bench for img_line_tap3 against a frame-array reference model.
module tb_img_line_tap3;

   localparam int W  = 8;
   localparam int H  = 3;
   localparam int DW = 24;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   img_line_tap3_if #(.IMG_WIDTH_DATA(DW)) pix_bus ();

   img_line_tap3 #(
      .IMG_WIDTH_DATA(DW),
      .IMG_WIDTH_LINE(W),
      .IMG_HEIGHT    (H)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .pix    (pix_bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: raster position and the pixels of the current frame by (row, col).
   int              m_col, m_row;
   logic [DW-1:0]   img [H][W];
   logic [DW-1:0]   line4 [W];
   logic            e_valid, e_sof, e_eol;
   logic [10:0]     e_col;
   logic [9:0]      e_row;
   logic [DW-1:0]   e_tap0, e_tap1, e_tap2;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check_eq("out_valid", 32'(pix_bus.out_valid), 32'(e_valid));
      check_eq("out_sof",   32'(pix_bus.out_sof),   32'(e_sof));
      check_eq("out_eol",   32'(pix_bus.out_eol),   32'(e_eol));
      check_eq("out_col",   32'(pix_bus.out_col),   32'(e_col));
      check_eq("out_row",   32'(pix_bus.out_row),   32'(e_row));
      check_eq("tap0",      32'(pix_bus.tap0),      32'(e_tap0));
      check_eq("tap1",      32'(pix_bus.tap1),      32'(e_tap1));
      check_eq("tap2",      32'(pix_bus.tap2),      32'(e_tap2));
   endtask

   task automatic model_reset();
      m_col   = 0;
      m_row   = 0;
      e_valid = 1'b0;
      e_sof   = 1'b0;
      e_eol   = 1'b0;
      e_col   = '0;
      e_row   = '0;
      e_tap0  = '0;
      e_tap1  = '0;
      e_tap2  = '0;
   endtask

   function automatic logic [DW-1:0] pattern(input int r, input int c);
      return DW'(r * 16 + c);
   endfunction

   // One clock: present a pixel (or idle), update the model, check after the edge.
   task automatic step(input bit v, input bit sof, input logic [DW-1:0] d);
      int pc, pr;
      pix_bus.in_valid = v;
      pix_bus.in_sof   = sof;
      pix_bus.in_data  = d;
      e_valid = v;
      e_sof   = 1'b0;
      e_eol   = 1'b0;
      if (v) begin
         pc     = sof ? 0 : m_col;
         pr     = sof ? 0 : m_row;
         e_tap0 = d;
         e_tap1 = (pr >= 1) ? img[pr-1][pc] : '0;
         e_tap2 = (pr >= 2) ? img[pr-2][pc] : '0;
         img[pr][pc] = d;
         e_col  = 11'(pc);
         e_row  = 10'(pr);
         e_sof  = (pc == 0) && (pr == 0);
         e_eol  = (pc == W - 1);
         m_col  = pc + 1;
         m_row  = pr;
         if (m_col == W) begin
            m_col = 0;
            m_row = (pr + 1) % H;
         end
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic idle_gap();
      repeat ($urandom_range(0, 1)) step(1'b0, 1'b0, DW'($urandom));
   endtask

   task automatic async_reset();
      reset_n          = 1'b0;
      pix_bus.in_valid = 1'b0;
      pix_bus.in_sof   = 1'b0;
      #1;
      model_reset();
      check_outputs();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      reset_n = 1'b1;
   endtask

   initial begin
      logic [DW-1:0] d;
      pix_bus.in_valid = 1'b0;
      pix_bus.in_sof   = 1'b0;
      pix_bus.in_data  = '0;

      // Reset then idle
      #2;
      model_reset();
      check_outputs();
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (4) step(1'b0, 1'b0, '0);

      // Three continuous lines, pixel = row*16+col
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < W; c++) begin
            step(1'b1, (r == 0) && (c == 0), pattern(r, c));
            if (r == 1 && c == 5) begin
               check_eq("r1c5_tap0", 32'(pix_bus.tap0), 32'h15);
               check_eq("r1c5_tap1", 32'(pix_bus.tap1), 32'h05);
               check_eq("r1c5_tap2", 32'(pix_bus.tap2), 32'h00);
            end
            if (r == 2 && c == 7) begin
               check_eq("r2c7_tap0", 32'(pix_bus.tap0), 32'h27);
               check_eq("r2c7_tap1", 32'(pix_bus.tap1), 32'h17);
               check_eq("r2c7_tap2", 32'(pix_bus.tap2), 32'h07);
               check_eq("r2c7_eol",  32'(pix_bus.out_eol), 32'h1);
            end
         end
      end

      // Same stream with random gaps; frame wraps implicitly (no sof)
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < W; c++) begin
            idle_gap();
            step(1'b1, 1'b0, pattern(r, c));
            if (r == 2 && c == 6) begin
               check_eq("gap_r2c6_tap1", 32'(pix_bus.tap1), 32'h16);
               check_eq("gap_r2c6_tap2", 32'(pix_bus.tap2), 32'h06);
            end
         end
      end

      // Frame wrap: 4th and 5th lines of random data
      for (int c = 0; c < W; c++) begin
         line4[c] = DW'($urandom);
         step(1'b1, 1'b0, line4[c]);
         check_eq("wrap_row",  32'(pix_bus.out_row), 32'h0);
         check_eq("wrap_tap1", 32'(pix_bus.tap1),    32'h0);
      end
      for (int c = 0; c < W; c++) begin
         step(1'b1, 1'b0, DW'($urandom));
         check_eq("line5_tap1", 32'(pix_bus.tap1), 32'(line4[c]));
      end
      for (int c = 0; c < W; c++) step(1'b1, 1'b0, DW'($urandom));

      // sof at row 1 col 3
      for (int i = 0; i < W + 3; i++) step(1'b1, 1'b0, DW'($urandom));
      step(1'b1, 1'b1, DW'($urandom));
      check_eq("midsof_sof",  32'(pix_bus.out_sof), 32'h1);
      check_eq("midsof_row",  32'(pix_bus.out_row), 32'h0);
      check_eq("midsof_col",  32'(pix_bus.out_col), 32'h0);
      check_eq("midsof_tap1", 32'(pix_bus.tap1),    32'h0);
      check_eq("midsof_tap2", 32'(pix_bus.tap2),    32'h0);
      step(1'b1, 1'b0, DW'($urandom));
      check_eq("midsof_next_col", 32'(pix_bus.out_col), 32'h1);
      for (int i = 0; i < 3 * W; i++) begin
         idle_gap();
         step(1'b1, 1'b0, DW'($urandom));
      end

      // Reset at row 2 col 4, resume without sof
      step(1'b1, 1'b1, DW'($urandom));
      for (int i = 1; i < 2 * W + 4; i++) step(1'b1, 1'b0, DW'($urandom));
      async_reset();
      step(1'b1, 1'b0, DW'($urandom));
      check_eq("postrst_row",  32'(pix_bus.out_row), 32'h0);
      check_eq("postrst_col",  32'(pix_bus.out_col), 32'h0);
      check_eq("postrst_tap1", 32'(pix_bus.tap1),    32'h0);
      check_eq("postrst_tap2", 32'(pix_bus.tap2),    32'h0);
      for (int i = 0; i < 3 * W; i++) begin
         idle_gap();
         step(1'b1, 1'b0, DW'($urandom));
      end

      // Free-running random traffic with occasional sof
      for (int i = 0; i < 400; i++) begin
         d = DW'($urandom);
         step($urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0, d);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
